icu_wide: RTL and testbench

- Parametrised successor to the 1-bit MC14500B-style ICU.
- DATA_W-bit result register; integrated program counter; hardware return-address stack for JMP/RTN.
- Single-edge (posedge) execution.
- Sits between a combinational-read program ROM (pc → opcode + operand) and a DATA_W-wide I/O/data space addressed by the operand.

---
 rtl/icu_wide_pkg.sv | 28 ++
 rtl/icu_wide_return_stack.sv | 54 +++++
 rtl/icu_wide.sv | 157 +++++++++++++++
 tb/tb_icu_wide.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icu_wide_pkg.sv
// Shared definitions for the wide ICU: the 4-bit opcode encoding and a
// small decode helper. Nothing here depends on the data width.
package icu_wide_pkg;

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } instruction_t;

    function automatic logic is_store(instruction_t op);
        return (op == OP_STO) || (op == OP_STOC);
    endfunction

endpackage

// File: rtl/icu_wide_return_stack.sv
// Return-address stack for JMP/RTN.
// Ports:
//   clk, rst        clock, async active-high reset
//   push, pop       push push_data / drop top entry (ignored when full / empty)
//   push_data       return address to store
//   top             most recently pushed address (0 when empty)
//   full, empty     occupancy status; the parent uses these to flag errors
module icu_return_stack
    import icu_wide_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]   sp_q;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    // sp points at the next free slot, so the top lives at sp-1.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SP_W'(i + 1) == sp_q) top = mem_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SP_W'(i) == sp_q) mem_q[i] <= push_data;
            end
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/icu_wide.sv
// Wide MC14500B-style industrial control unit: DATA_W-bit result register,
// internal program counter and return-address stack. Executes one
// instruction per rising edge; strobes and write data are combinational.
// Ports:
//   clk, rst              clock, async active-high reset
//   instruction, operand  ROM word at pc
//   data_in               read data at addr
//   pc                    program counter to ROM
//   addr                  data address (= operand)
//   data_out, write       store data and strobe
//   jmp, rtn              taken JMP / RTN this cycle
//   flag_o, flag_f        NOPO / NOPF this cycle
//   stack_err             sticky stack overflow/underflow
//   rr_out                result register
module icu_wide
    import icu_wide_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        instruction,
    input  logic [ADDR_W-1:0] operand,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic              jmp,
    output logic              rtn,
    output logic              flag_o,
    output logic              flag_f,
    output logic              stack_err,
    output logic [DATA_W-1:0] rr_out
);

    instruction_t      op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rr_q, rr_d;
    logic              ien_q, ien_d;
    logic              oen_q, oen_d;
    logic              skip_q, skip_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] din_m;
    logic              push, pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full, stk_empty;

    assign op        = instruction_t'(instruction);
    assign din_m     = ien_q ? data_in : '0;
    assign addr      = operand;
    assign pc        = pc_q;
    assign rr_out    = rr_q;
    assign stack_err = err_q;

    icu_return_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + ADDR_W'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_d     = pc_q + ADDR_W'(1);
        rr_d     = rr_q;
        ien_d    = ien_q;
        oen_d    = oen_q;
        skip_d   = 1'b0;
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
        write    = 1'b0;
        data_out = '0;
        jmp      = 1'b0;
        rtn      = 1'b0;
        flag_o   = 1'b0;
        flag_f   = 1'b0;

        // A pending skip squashes the whole instruction, including SKZ itself.
        if (!skip_q) begin
            case (op)
                OP_NOPO: flag_o = 1'b1;
                OP_LD:   rr_d = din_m;
                OP_LDC:  rr_d = ien_q ? ~data_in : '1;
                OP_AND:  rr_d = rr_q & din_m;
                OP_ANDC: rr_d = rr_q & ~din_m;
                OP_OR:   rr_d = rr_q | din_m;
                OP_ORC:  rr_d = ien_q ? (rr_q | ~data_in) : '1;
                OP_XNOR: rr_d = ~(rr_q ^ din_m);
                OP_IEN:  ien_d = data_in[0];
                OP_OEN:  oen_d = din_m[0];
                OP_JMP: begin
                    // Overflow still jumps; only the return address is lost.
                    if (stk_full) err_d = 1'b1;
                    else          push  = 1'b1;
                    pc_d = operand;
                    jmp  = 1'b1;
                end
                OP_RTN: begin
                    if (stk_empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                        rtn  = 1'b1;
                    end
                end
                OP_SKZ:  skip_d = (rr_q == '0);
                OP_NOPF: flag_f = 1'b1;
                default: ;
            endcase

            if (is_store(op) && oen_q) begin
                write    = 1'b1;
                data_out = (op == OP_STOC) ? ~rr_q : rr_q;
            end
        end

        // Strobes must drop the instant reset asserts, not at the next edge.
        if (rst) begin
            write    = 1'b0;
            data_out = '0;
            jmp      = 1'b0;
            rtn      = 1'b0;
            flag_o   = 1'b0;
            flag_f   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            rr_q   <= '0;
            ien_q  <= 1'b0;
            oen_q  <= 1'b0;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            rr_q   <= rr_d;
            ien_q  <= ien_d;
            oen_q  <= oen_d;
            skip_q <= skip_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_icu_wide.sv
module tb_icu_wide;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    instruction = 4'h0;
    logic [AW-1:0] operand = '0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] pc, addr;
    logic [DW-1:0] data_out, rr_out;
    logic          write, jmp, rtn, flag_o, flag_f, stack_err;

    icu_wide #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .operand     (operand),
        .data_in     (data_in),
        .pc          (pc),
        .addr        (addr),
        .data_out    (data_out),
        .write       (write),
        .jmp         (jmp),
        .rtn         (rtn),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .stack_err   (stack_err),
        .rr_out      (rr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
        logic [DW-1:0] rr;
        logic          wr, jmp, rtn, fo, ff, err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference machine state
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_rr;
    logic          m_ien, m_oen, m_skip, m_err;
    logic [AW-1:0] m_stack[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_rr = '0; m_ien = 0; m_oen = 0; m_skip = 0; m_err = 0;
        m_stack.delete();
    endtask

    // Expected outputs for this cycle use the state before the edge;
    // the model then advances to the post-edge state.
    task automatic model_step(input logic [3:0] op, input logic [AW-1:0] opnd, input logic [DW-1:0] din);
        exp_t          e;
        logic [DW-1:0] dm;
        logic [AW-1:0] nxt;
        e.pc = m_pc; e.addr = opnd; e.rr = m_rr; e.err = m_err;
        e.dout = '0; e.wr = 0; e.jmp = 0; e.rtn = 0; e.fo = 0; e.ff = 0;
        dm  = m_ien ? din : '0;
        nxt = m_pc + 1;
        if (m_skip) begin
            m_skip = 0;
        end else begin
            case (op)
                4'h0: e.fo = 1;
                4'h1: m_rr = dm;
                4'h2: m_rr = m_ien ? ~din : 8'hFF;
                4'h3: m_rr = m_rr & dm;
                4'h4: m_rr = m_rr & ~dm;
                4'h5: m_rr = m_rr | dm;
                4'h6: m_rr = m_ien ? (m_rr | ~din) : 8'hFF;
                4'h7: m_rr = ~(m_rr ^ dm);
                4'h8: if (m_oen) begin e.wr = 1; e.dout = m_rr; end
                4'h9: if (m_oen) begin e.wr = 1; e.dout = ~m_rr; end
                4'hA: m_ien = din[0];
                4'hB: m_oen = dm[0];
                4'hC: begin
                    if (m_stack.size() == SD) m_err = 1;
                    else m_stack.push_back(m_pc + 1);
                    nxt = opnd; e.jmp = 1;
                end
                4'hD: begin
                    if (m_stack.size() == 0) m_err = 1;
                    else begin nxt = m_stack.pop_back(); e.rtn = 1; end
                end
                4'hE: m_skip = (m_rr == 0);
                default: e.ff = 1;
            endcase
        end
        m_pc = nxt;
        sbq.push_back(e);
    endtask

    // One instruction per cycle; also releases reset if it was held.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] opnd, input logic [DW-1:0] din);
        @(negedge clk);
        #1;
        rst = 1'b0;
        instruction = op; operand = opnd; data_in = din;
        model_step(op, opnd, din);
    endtask

    // Monitor: every cycle the DUT presents a result, compare it to the head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc",        32'(pc),        32'(e.pc));
                chk("addr",      32'(addr),      32'(e.addr));
                chk("rr_out",    32'(rr_out),    32'(e.rr));
                chk("write",     32'(write),     32'(e.wr));
                chk("data_out",  32'(data_out),  32'(e.dout));
                chk("jmp",       32'(jmp),       32'(e.jmp));
                chk("rtn",       32'(rtn),       32'(e.rtn));
                chk("flag_o",    32'(flag_o),    32'(e.fo));
                chk("flag_f",    32'(flag_f),    32'(e.ff));
                chk("stack_err", 32'(stack_err), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_rr", 32'(rr_out), 0);
        chk("rst_err", 32'(stack_err), 0);
        chk("rst_flag_o", 32'(flag_o), 0);  // instruction=NOPO held in reset

        // Load / logic with inputs enabled
        issue(4'hA, 8'h00, 8'h01);
        issue(4'h1, 8'h00, 8'hA5);
        issue(4'h3, 8'h00, 8'h0F);
        issue(4'h0, 8'h00, 8'h00);
        #2;
        chk("and_rr", 32'(rr_out), 32'h05);
        chk("and_pc", 32'(pc), 3);

        // Inputs disabled: complement loads force all-ones, LD forces zero
        issue(4'hA, 8'h00, 8'h00);
        issue(4'h2, 8'h00, 8'h12);
        issue(4'h6, 8'h00, 8'h34);
        issue(4'h1, 8'h00, 8'h3C);
        issue(4'h0, 8'h00, 8'h00);
        #2;
        chk("ien0_ld_rr", 32'(rr_out), 0);

        // Output enable gating and STOC
        issue(4'hB, 8'h00, 8'h01);          // din_m is 0, so oen stays 0
        issue(4'h8, 8'h10, 8'h00);
        issue(4'hA, 8'h00, 8'h01);
        issue(4'h1, 8'h00, 8'h05);
        issue(4'hB, 8'h00, 8'h01);
        issue(4'h9, 8'h44, 8'h00);
        #2;
        chk("stoc_write", 32'(write), 1);
        chk("stoc_data", 32'(data_out), 32'hFA);
        chk("stoc_addr", 32'(addr), 32'h44);

        // Skip on zero, then skip not taken
        issue(4'h1, 8'h00, 8'h00);
        issue(4'hE, 8'h00, 8'h00);
        issue(4'h1, 8'h00, 8'h77);
        issue(4'hE, 8'h00, 8'h00);          // rr still 0: skips the next SKZ
        issue(4'hE, 8'h00, 8'h00);          // squashed SKZ must not re-arm
        issue(4'h1, 8'h00, 8'h09);
        issue(4'hE, 8'h00, 8'h00);
        issue(4'h1, 8'h00, 8'h77);

        // Stack: reset, reach pc=5, JMP/RTN, overflow, underflow
        #2; rst = 1'b1; model_reset();
        repeat (5) issue(4'h0, 8'h00, 8'h00);
        issue(4'hC, 8'h20, 8'h00);
        issue(4'hD, 8'h00, 8'h00);
        issue(4'h0, 8'h00, 8'h00);
        #2;
        chk("rtn_pc", 32'(pc), 6);
        for (int i = 0; i <= SD; i++) issue(4'hC, AW'(8'h40 + 8'(i * 8)), 8'h00);
        issue(4'h0, 8'h00, 8'h00);
        #2;
        chk("ovf_err", 32'(stack_err), 1);
        chk("ovf_taken_pc", 32'(pc), 32'h60);
        for (int i = 0; i <= SD; i++) issue(4'hD, 8'h00, 8'h00);

        // Randomized run from a clean state
        #2; rst = 1'b1; model_reset();
        for (int i = 0; i < 3000; i++)
            issue(4'($urandom_range(0, 15)), AW'($urandom), DW'($urandom));

        // Async reset in the middle of a store
        issue(4'hA, 8'h00, 8'h01);
        issue(4'h1, 8'h00, 8'h5A);
        issue(4'hB, 8'h00, 8'h01);
        issue(4'h8, 8'h33, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_write", 32'(write), 0);
        chk("arst_data", 32'(data_out), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_rr", 32'(rr_out), 0);
        chk("arst_err", 32'(stack_err), 0);
        model_reset();
        issue(4'h0, 8'h00, 8'h00);
        issue(4'hF, 8'h00, 8'h00);
        issue(4'h0, 8'h00, 8'h00);
        @(negedge clk);
        #3;
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
